// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for round_robin_arbiter and its rr_pick helper.
package round_robin_arbiter_pkg;

    localparam logic ARB_IDLE    = 1'b0;
    localparam logic ARB_GRANTED = 1'b1;

    localparam int unsigned ARB_MAX_INPUTS      = 8;
    localparam int unsigned ARB_DEFAULT_TIMEOUT = 256;

    typedef enum logic {
        StIdle    = ARB_IDLE,
        StGranted = ARB_GRANTED
    } arb_state_e;

    // Rotating pointer advance: one past idx, wrapping to 0 after the last requester.
    function automatic int unsigned arb_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_rr_pick.sv
// Combinational rotating-priority picker: lowest requesting, non-excluded bit at or
// after pointer, searching modulo INPUTS.
module rr_pick
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned INPUTS      = 4,
    parameter int unsigned INDEX_WIDTH = 3
) (
    input  logic [INPUTS-1:0]      request,
    input  logic [INPUTS-1:0]      exclude,
    input  logic [INDEX_WIDTH-1:0] pointer,
    output logic [INPUTS-1:0]      pick,
    output logic [INDEX_WIDTH-1:0] pick_index,
    output logic                   valid
);

    logic [INPUTS-1:0] cand;
    logic [INPUTS-1:0] rotated;
    int unsigned       pos;

    assign cand = request & ~exclude;
    // Bit k of rotated is candidate (pointer + k) mod INPUTS.
    assign rotated = INPUTS'({cand, cand} >> pointer);

    always_comb begin
        pick       = '0;
        pick_index = '0;
        valid      = 1'b0;
        pos        = 0;
        for (int unsigned k = 0; k < INPUTS; k++) begin
            if (!valid && rotated[k]) begin
                valid      = 1'b1;
                pos        = (32'(pointer) + k) % INPUTS;
                pick       = INPUTS'(1) << pos;
                pick_index = INDEX_WIDTH'(pos);
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant held for the owner's whole tenure.
// Optional forced release after TIMEOUT_CYCLES when built with ARBITER_TIMEOUT_EN.
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned INPUTS         = 4,
    parameter int unsigned INDEX_WIDTH    = 3,
    parameter int unsigned TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUTS-1:0]      request,
    output logic [INPUTS-1:0]      grant,
    output logic [INDEX_WIDTH-1:0] grantIndex,
    output logic                   busy
`ifdef ARBITER_TIMEOUT_EN
    ,
    output logic                   timeoutPulse
`endif
);

    arb_state_e             state_q, state_d;
    logic [INPUTS-1:0]      grant_q, grant_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] pointer_q, pointer_d;

    logic [INPUTS-1:0]      exclude;
    logic [INPUTS-1:0]      pick;
    logic [INDEX_WIDTH-1:0] pick_index;
    logic                   pick_valid;
    logic                   owner_req;
    logic                   release_grant;

`ifdef ARBITER_TIMEOUT_EN
    logic [15:0]       count_q, count_d;
    logic [INPUTS-1:0] blocked_q, blocked_d;
    logic              pulse_q, pulse_d;

    // The current owner is excluded so a handover never re-picks it.
    assign exclude = grant_q | blocked_q;
`else
    assign exclude = grant_q;
`endif

    assign owner_req = |(request & grant_q);

    rr_pick #(
        .INPUTS      (INPUTS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .request    (request),
        .exclude    (exclude),
        .pointer    (pointer_q),
        .pick       (pick),
        .pick_index (pick_index),
        .valid      (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        index_d       = index_q;
        pointer_d     = pointer_q;
        release_grant = 1'b0;
`ifdef ARBITER_TIMEOUT_EN
        count_d   = count_q;
        pulse_d   = 1'b0;
        blocked_d = blocked_q & request;
`endif
        unique case (state_q)
            StIdle: release_grant = 1'b1;
            StGranted: begin
                if (!owner_req) begin
                    release_grant = 1'b1;
`ifdef ARBITER_TIMEOUT_EN
                end else if (count_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    release_grant = 1'b1;
                    pulse_d       = 1'b1;
                    blocked_d     = blocked_d | grant_q;
                end else begin
                    count_d = count_q + 16'd1;
`endif
                end
            end
        endcase

        if (release_grant) begin
            if (pick_valid) begin
                state_d   = StGranted;
                grant_d   = pick;
                index_d   = pick_index;
                pointer_d = INDEX_WIDTH'(arb_wrap_inc(32'(pick_index), INPUTS));
            end else begin
                state_d = StIdle;
                grant_d = '0;
                index_d = '0;
            end
`ifdef ARBITER_TIMEOUT_EN
            count_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            index_q   <= '0;
            pointer_q <= '0;
`ifdef ARBITER_TIMEOUT_EN
            count_q   <= '0;
            blocked_q <= '0;
            pulse_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            index_q   <= index_d;
            pointer_q <= pointer_d;
`ifdef ARBITER_TIMEOUT_EN
            count_q   <= count_d;
            blocked_q <= blocked_d;
            pulse_q   <= pulse_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign grantIndex = index_q;
    assign busy       = |grant_q;
`ifdef ARBITER_TIMEOUT_EN
    assign timeoutPulse = pulse_q;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: 4-input DUT driven from a vector table,
// plus a 1-input DUT; timeout sequence runs when ARBITER_TIMEOUT_EN is defined.
module tb_round_robin_arbiter;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [2:0] idx;
        logic       pulse;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [2:0] idx;
        logic       pulse;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] request = 4'b0000;
    logic [3:0] grant;
    logic [2:0] grant_index;
    logic       busy;
    logic       timeout_pulse;

    logic       request1 = 1'b0;
    logic       grant1;
    logic       grant_index1;
    logic       busy1;
    logic       timeout_pulse1;

    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    round_robin_arbiter #(
        .INPUTS         (4),
        .INDEX_WIDTH    (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .request      (request),
        .grant        (grant),
        .grantIndex   (grant_index),
        .busy         (busy)
`ifdef ARBITER_TIMEOUT_EN
        ,
        .timeoutPulse (timeout_pulse)
`endif
    );

    round_robin_arbiter #(
        .INPUTS      (1),
        .INDEX_WIDTH (1)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .request      (request1),
        .grant        (grant1),
        .grantIndex   (grant_index1),
        .busy         (busy1)
`ifdef ARBITER_TIMEOUT_EN
        ,
        .timeoutPulse (timeout_pulse1)
`endif
    );

`ifndef ARBITER_TIMEOUT_EN
    assign timeout_pulse  = 1'b0;
    assign timeout_pulse1 = 1'b0;
`endif

    always @(negedge clk) begin
        if (!rst) begin
            assert (!$isunknown(request)) else $error("X on request");
            assert ($onehot0(grant)) else $error("grant not onehot0");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic [3:0] g, input logic [2:0] idx,
                       input logic pulse);
        vec_t v;
        v.req = req; v.grant = g; v.idx = idx; v.pulse = pulse;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [3:0] req, input logic [3:0] g, input logic [2:0] idx,
                        input logic pulse);
        exp_t e;
        @(negedge clk);
        request = req;
        e.grant = g; e.idx = idx; e.pulse = pulse;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("grant", 32'(grant), 32'(e.grant));
            check("grantIndex", 32'(grant_index), 32'(e.idx));
            check("busy", 32'(busy), 32'(e.grant != 4'b0000));
`ifdef ARBITER_TIMEOUT_EN
            check("timeoutPulse", 32'(timeout_pulse), 32'(e.pulse));
`endif
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].grant, tbl[i].idx, tbl[i].pulse);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        request = 4'b0000;
        request1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic p1 [5];
        p1[0] = 1'b1; p1[1] = 1'b0; p1[2] = 1'b1; p1[3] = 1'b1; p1[4] = 1'b0;

        // Reset state while rst is held.
        #2;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_index", 32'(grant_index), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset release.
        for (int i = 0; i < 10; i++) add(4'b0000, 4'b0000, 3'd0, 1'b0);
        // Single request, then no preemption by master 0.
        add(4'b0100, 4'b0100, 3'd2, 1'b0);
        add(4'b0100, 4'b0100, 3'd2, 1'b0);
        add(4'b0101, 4'b0100, 3'd2, 1'b0);
        add(4'b0101, 4'b0100, 3'd2, 1'b0);
        add(4'b0101, 4'b0100, 3'd2, 1'b0);
        add(4'b0001, 4'b0001, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        add(4'b0010, 4'b0010, 3'd1, 1'b0);
        run_table();

        // Asynchronous reset mid-tenure clears grant without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        request = 4'b0000;
        @(negedge clk);
        rst = 1'b0;

        // All request: strict rotation, each owner drops after three granted cycles.
        add(4'b1111, 4'b0001, 3'd0, 1'b0);
        add(4'b1111, 4'b0001, 3'd0, 1'b0);
        add(4'b1111, 4'b0001, 3'd0, 1'b0);
        add(4'b1110, 4'b0010, 3'd1, 1'b0);
        add(4'b1111, 4'b0010, 3'd1, 1'b0);
        add(4'b1111, 4'b0010, 3'd1, 1'b0);
        add(4'b1101, 4'b0100, 3'd2, 1'b0);
        add(4'b1111, 4'b0100, 3'd2, 1'b0);
        add(4'b1111, 4'b0100, 3'd2, 1'b0);
        add(4'b1011, 4'b1000, 3'd3, 1'b0);
        add(4'b1111, 4'b1000, 3'd3, 1'b0);
        add(4'b1111, 4'b1000, 3'd3, 1'b0);
        add(4'b0111, 4'b0001, 3'd0, 1'b0);
        add(4'b1111, 4'b0001, 3'd0, 1'b0);
        // Owner 1 drops with 4'b1001 pending and pointer at 2.
        add(4'b0010, 4'b0010, 3'd1, 1'b0);
        add(4'b1011, 4'b0010, 3'd1, 1'b0);
        add(4'b1001, 4'b1000, 3'd3, 1'b0);
        add(4'b0001, 4'b0001, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        run_table();

        // Single-input build: grant follows request one cycle later.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            request1 = p1[i];
            @(posedge clk);
            #1;
            check("inputs1_grant", 32'(grant1), 32'(p1[i]));
            check("inputs1_index", 32'(grant_index1), 32'd0);
        end

`ifdef ARBITER_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 8; i++) add(4'b0011, 4'b0001, 3'd0, 1'b0);
        add(4'b0011, 4'b0010, 3'd1, 1'b1);
        add(4'b0011, 4'b0010, 3'd1, 1'b0);
        add(4'b0001, 4'b0000, 3'd0, 1'b0);
        add(4'b0001, 4'b0000, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        add(4'b0001, 4'b0001, 3'd0, 1'b0);
        run_table();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
